memoria_instrucciones_cargable: RTL
===================================

# memoria_instrucciones_cargable

Parametrised, loadable instruction memory for the pipeline's IF stage. It clears itself to NOP after reset, then accepts program words through a valid/ready load port. It serves registered fetches with stall and flush control from the hazard and branch logic. An optional per-word parity check substitutes a NOP and flags an error on corruption.

## Interface
- ADDR_W, 10, fetch/load address width
- DEPTH, 1024, number of words; must be ≤ 2^ADDR_W
- DATA_W, 32, instruction width
- NOP_WORD, 32'h00000000, word used for clear, flush and fault substitution
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch request
- fetch_ready  out  1  fetch accepted this edge when both valid and ready are high
- direccion  in  ADDR_W  fetch word address (PC word index)
- stall  in  1  hold the current output
- flush  in  1  kill the output and replace it with NOP_WORD
- instruccion  out  DATA_W  registered instruction
- instr_valid  out  1  instruccion holds a fetched word
- load_valid  in  1  load request
- load_ready  out  1  load accepted when both valid and ready are high
- load_addr  in  ADDR_W  load word address
- load_data  in  DATA_W  load word
- init_done  out  1  clear sweep finished
- addr_fault  out  1  one-cycle pulse: out-of-range fetch or load
- parity_error  out  1  one-cycle pulse: parity mismatch on fetch (IMEM_PARITY_EN only)

## Operation
- FSM states are CLEAR and RUN; rst_n low forces CLEAR with the sweep counter at 0.
- CLEAR:
  - writes NOP_WORD to word `counter` each edge and increments the counter;
  - after word DEPTH-1 is written, moves to RUN and sets init_done=1;
  - fetch_ready=0 and load_ready=0 throughout.
- RUN:
  - load_ready=1;
  - fetch_ready = !load_valid && !stall && !flush, so a load has priority over a fetch on the single port.
- Accepted load: writes load_data at the edge. If load_addr ≥ DEPTH, nothing is written and addr_fault pulses.
- Accepted fetch: at the edge, instruccion ← mem[direccion] and instr_valid ← 1. If direccion ≥ DEPTH, instruccion ← NOP_WORD, instr_valid ← 1 and addr_fault pulses.
- stall=1 (and no flush): instruccion and instr_valid hold.
- flush=1: instruccion ← NOP_WORD and instr_valid ← 0. Flush overrides stall, fetch and hold.
- RUN with no fetch accepted, no stall and no flush: instr_valid ← 0 and instruccion holds its value.
- Memory contents are not reset by rst_n; only the CLEAR sweep initialises them.

## Timing
- Reset values: instruccion=NOP_WORD, instr_valid=0, fetch_ready=0, load_ready=0, init_done=0, addr_fault=0, parity_error=0.
- Clear latency: init_done rises after exactly DEPTH rising edges following rst_n release.
- Fetch latency: 1 cycle from the accepting edge to valid instruccion.
- Throughput: 1 fetch per cycle.
- Read-after-load at the same address: a fetch accepted on the edge after the load edge returns the new data. Reads are never bypassed within the same edge, because the two cannot be accepted together.
- Reset asserted mid-CLEAR or mid-RUN: the FSM immediately enters CLEAR, outputs take their reset values, and a full sweep restarts.
- addr_fault and parity_error pulse high for exactly the one cycle following the offending edge.

## Configuration
- IMEM_PARITY_EN defined:
  - the array stores DATA_W+1 bits, with even parity computed on every write (clear and load);
  - each fetch recomputes parity; on mismatch, instruccion ← NOP_WORD, instr_valid ← 1 and parity_error pulses.
- IMEM_PARITY_EN undefined: no parity bit is stored, and parity_error is tied to 0.

## Structure
- Package memoria_pkg holds:
  - the state enum (CLEAR, RUN);
  - the default NOP_WORD;
  - the even-parity function.
- Sub-module memoria_ram_sp is a single-port synchronous RAM (write enable, address, write data, registered read data).
- The top level contains the FSM, sweep counter, port arbitration, range checks and output register.

## Test plan
- Clear sweep: release reset with DEPTH=16 → init_done=0 for 16 edges then 1. A fetch of every address 0..15 returns 32'h00000000 with instr_valid=1.
- Load then fetch: load 32'h00210820 at addr 4, fetch addr 4 on the next edge → instruccion=32'h00210820 one cycle later. Assert load_valid and fetch_valid together → fetch_ready=0 that cycle.
- Stall/flush: stream fetches of addrs 0..3 loaded with 0x11..0x44, assert stall during the addr-2 fetch → output 0x22 holds. Assert flush with stall → instruccion=NOP_WORD and instr_valid=0.
- Range fault: DEPTH=1000, fetch addr 1010 → instruccion=NOP_WORD and a 1-cycle addr_fault. Load at addr 1005 → no write and addr_fault pulses.
- Reset mid-sweep: drop rst_n at sweep word 7 → outputs return to reset values; after release init_done takes a full DEPTH edges again.
- Parity (IMEM_PARITY_EN): load 0xA5A5A5A5 at addr 3, force-flip one stored bit, fetch addr 3 → instruccion=NOP_WORD, 1-cycle parity_error, instr_valid=1.

Source files
------------

// File: rtl/memoria_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// The optional parity protection is selected with the IMEM_PARITY_EN macro.
package memoria_pkg;

    // Controller phases: CLEAR sweeps NOP through the array, RUN serves traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } estado_e;

    // Default instruction used for clear, flush and fault substitution.
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Even parity bit: XOR of all data bits, so data plus bit always XORs to 0.
    // Zero-extension to 64 bits does not change the result.
    function automatic logic paridad_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/memoria_ram_sp.sv
// Single-port synchronous RAM: write has priority; the read register only
// updates on a read enable so the last fetched word stays stable.
module memoria_ram_sp
    import memoria_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0] idx;

    // Callers guarantee addr < DEPTH whenever we or re is set.
    assign idx   = addr[IDX_W-1:0];
    assign rdata = rdata_q;

    // Array write / registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end else if (re) begin
            rdata_q <= mem[idx];
        end
    end

endmodule

// File: rtl/memoria_instrucciones_cargable.sv
// Loadable instruction memory for the IF stage: NOP clear sweep after reset,
// valid/ready load port, registered fetch with stall/flush, range faults.
// Define IMEM_PARITY_EN to store an even-parity bit per word and replace
// corrupted fetches with NOP while pulsing parity_error.
module memoria_instrucciones_cargable
    import memoria_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 1024,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] direccion,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instruccion,
    output logic              instr_valid,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              init_done,
    output logic              addr_fault,
    output logic              parity_error
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // Extra bit so DEPTH == 2**ADDR_W compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);

    estado_e           state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              nop_sel_q, nop_sel_d;   // output shows NOP instead of RAM data
    logic              fault_q, fault_d;
    logic              fetched_q, fetched_d;   // RAM read register was just refreshed

    logic              load_acc, fetch_acc;
    logic              load_oor, fetch_oor;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [MEM_W-1:0]  ram_wdata, ram_rdata;
    logic [DATA_W-1:0] wr_word;
    logic              mismatch;

    assign load_oor  = {1'b0, load_addr} >= DEPTH_L;
    assign fetch_oor = {1'b0, direccion} >= DEPTH_L;

    // Port arbitration: a pending load always wins the single RAM port.
    always_comb begin
        load_ready  = 1'b0;
        fetch_ready = 1'b0;
        if (state_q == RUN) begin
            load_ready  = 1'b1;
            fetch_ready = !load_valid && !stall && !flush;
        end
        load_acc  = load_valid && load_ready;
        fetch_acc = fetch_valid && fetch_ready;
    end

    // RAM port control: sweep writes, in-range loads and in-range fetches.
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = direccion;
        wr_word  = load_data;
        if (state_q == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = cnt_q;
            wr_word  = NOP_WORD;
        end else if (load_acc) begin
            ram_we   = !load_oor;
            ram_addr = load_addr;
        end else begin
            ram_re = fetch_acc && !fetch_oor;
        end
`ifdef IMEM_PARITY_EN
        ram_wdata = {paridad_par(64'(wr_word)), wr_word};
`else
        ram_wdata = wr_word;
`endif
    end

    memoria_ram_sp #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // FSM next state, sweep counter and output-control next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        nop_sel_d = nop_sel_q;
        fault_d   = 1'b0;
        fetched_d = 1'b0;

        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_W) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end

        fault_d = (load_acc && load_oor) || (fetch_acc && fetch_oor);

        // Flush beats stall beats fetch beats idle.
        if (flush) begin
            nop_sel_d = 1'b1;
            valid_d   = 1'b0;
        end else if (stall) begin
            nop_sel_d = nop_sel_q;
            valid_d   = valid_q;
        end else if (fetch_acc) begin
            valid_d   = 1'b1;
            nop_sel_d = fetch_oor;
            fetched_d = !fetch_oor;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            nop_sel_q <= 1'b1;
            fault_q   <= 1'b0;
            fetched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            nop_sel_q <= nop_sel_d;
            fault_q   <= fault_d;
            fetched_q <= fetched_d;
        end
    end

    // The RAM read register holds the fetched word; a held corrupted word
    // keeps mismatching, so the NOP substitution persists through stalls.
`ifdef IMEM_PARITY_EN
    assign mismatch     = ^ram_rdata;
    assign parity_error = fetched_q && mismatch;
`else
    assign mismatch     = 1'b0;
    assign parity_error = 1'b0;
`endif

    // Output view: NOP when selected or when the stored word failed parity.
    always_comb begin
        instruccion = ram_rdata[DATA_W-1:0];
        if (nop_sel_q || mismatch) begin
            instruccion = NOP_WORD;
        end
    end

    assign instr_valid = valid_q;
    assign init_done   = (state_q == RUN);
    assign addr_fault  = fault_q;

endmodule
